// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle control sequencer: state encodings,
// opcode values, writeback/PC select codes and the Moore output decode.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd7
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;

  localparam logic [1:0] PC_SEL_PLUS4  = 2'd0;
  localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
  localparam logic [1:0] PC_SEL_ALU    = 2'd2;

  typedef struct packed {
    logic       imem_req;
    logic       control_override;
    logic       alu_src_imm;
    logic       alu_src_pc;
    logic       dmem_req;
    logic       dmem_we;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic       pc_en;
    logic [1:0] pc_sel;
    logic       instr_retired;
    logic       trap;
  } ctrl_out_t;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
      OP_LOAD, OP_STORE, OP_OPIMM, OP_OP: is_legal = 1'b1;
      default:                            is_legal = 1'b0;
    endcase
  endfunction

  // Outputs the controller presents while sitting in state st with opcode op.
  function automatic ctrl_out_t decode_outputs(input state_t st, input logic [6:0] op);
    ctrl_out_t o;
    o = '0;
    case (st)
      ST_FETCH: o.imem_req = 1'b1;
      ST_EXEC: begin
        o.control_override = (op == OP_LOAD) || (op == OP_STORE) || (op == OP_AUIPC) ||
                             (op == OP_JAL) || (op == OP_JALR);
        o.alu_src_imm      = !((op == OP_OP) || (op == OP_BRANCH));
        o.alu_src_pc       = (op == OP_AUIPC) || (op == OP_JAL);
        if (op == OP_BRANCH) begin
          o.pc_en         = 1'b1;
          o.instr_retired = 1'b1;
        end
      end
      ST_MEM: begin
        o.dmem_req = 1'b1;
        o.dmem_we  = (op == OP_STORE);
      end
      ST_WB: begin
        o.reg_we        = 1'b1;
        o.pc_en         = 1'b1;
        o.instr_retired = 1'b1;
        if (op == OP_LOAD)                         o.wb_sel = WB_SEL_MEM;
        else if ((op == OP_JAL) || (op == OP_JALR)) o.wb_sel = WB_SEL_PC4;
        else                                       o.wb_sel = WB_SEL_ALU;
        if (op == OP_JAL)       o.pc_sel = PC_SEL_BRANCH;
        else if (op == OP_JALR) o.pc_sel = PC_SEL_ALU;
        else                    o.pc_sel = PC_SEL_PLUS4;
      end
      ST_TRAP: o.trap = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_ack_timeout.sv
// Wait counter for memory handshakes: counts cycles spent waiting for an ack
// and flags expiry once the budget of MEM_TIMEOUT cycles is used up.
module ack_timeout #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic count_en,
  output logic expired
);

  localparam int CW = $clog2(MEM_TIMEOUT) + 1;

  logic [CW-1:0] count;

  // Any cycle that is not an unanswered wait restarts the budget.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!count_en) begin
      count <= '0;
    end else if (count != '1) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer: fetches one instruction at a time into the
// instruction register and steps it through EXEC/MEM/WB, trapping on errors.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int N           = 32,
  parameter int OPCODE_W    = 7,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         imem_ack,
  input  logic [N-1:0] imem_rdata,
  input  logic         dmem_ack,
  input  logic         branch_taken,
  output logic         imem_req,
  output logic [N-1:0] instr_q,
  output logic         control_override,
  output logic         alu_src_imm,
  output logic         alu_src_pc,
  output logic         dmem_req,
  output logic         dmem_we,
  output logic         reg_we,
  output logic [1:0]   wb_sel,
  output logic         pc_en,
  output logic [1:0]   pc_sel,
  output logic         instr_retired,
  output logic         trap,
  output logic [2:0]   state_o
);

  state_t               state, state_nxt;
  logic [N-1:0]         instr_nxt;
  ctrl_out_t            outs_q, outs_nxt;
  logic [OPCODE_W-1:0]  op_q;
  logic                 fetch_ack, mem_ack, waiting, expired;
  logic                 store_done, branch_exec;

  assign op_q      = instr_q[OPCODE_W-1:0];
  // An ack only counts while the matching request is actually being driven.
  assign fetch_ack = (state == ST_FETCH) && outs_q.imem_req && imem_ack;
  assign mem_ack   = (state == ST_MEM) && dmem_ack;
  assign waiting   = ((state == ST_FETCH) && outs_q.imem_req) || (state == ST_MEM);

  ack_timeout #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .count_en (waiting && !(fetch_ack || mem_ack)),
    .expired  (expired)
  );

  always_comb begin
    state_nxt = state;
    instr_nxt = instr_q;
    case (state)
      ST_FETCH: begin
        if (fetch_ack) begin
          instr_nxt = imem_rdata;
          state_nxt = ST_DECODE;
        end else if (expired) begin
          state_nxt = ST_TRAP;
        end
      end
      ST_DECODE: state_nxt = is_legal(op_q) ? ST_EXEC : ST_TRAP;
      ST_EXEC: begin
        if (op_q == OP_BRANCH)                         state_nxt = ST_FETCH;
        else if ((op_q == OP_LOAD) || (op_q == OP_STORE)) state_nxt = ST_MEM;
        else                                           state_nxt = ST_WB;
      end
      ST_MEM: begin
        if (mem_ack)      state_nxt = (op_q == OP_STORE) ? ST_FETCH : ST_WB;
        else if (expired) state_nxt = ST_TRAP;
      end
      ST_WB:   state_nxt = ST_FETCH;
      ST_TRAP: state_nxt = ST_TRAP;
      default: state_nxt = ST_TRAP;
    endcase
    outs_nxt = decode_outputs(state_nxt, instr_nxt[OPCODE_W-1:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_FETCH;
      instr_q <= '0;
      outs_q  <= '0;
    end else begin
      state   <= state_nxt;
      instr_q <= instr_nxt;
      outs_q  <= outs_nxt;
    end
  end

  // Store completion and branch direction depend on same-cycle inputs.
  assign store_done  = (state == ST_MEM) && (op_q == OP_STORE) && dmem_ack;
  assign branch_exec = (state == ST_EXEC) && (op_q == OP_BRANCH);

  assign imem_req         = outs_q.imem_req;
  assign control_override = outs_q.control_override;
  assign alu_src_imm      = outs_q.alu_src_imm;
  assign alu_src_pc       = outs_q.alu_src_pc;
  assign dmem_req         = outs_q.dmem_req;
  assign dmem_we          = outs_q.dmem_we;
  assign reg_we           = outs_q.reg_we;
  assign wb_sel           = outs_q.wb_sel;
  assign pc_en            = outs_q.pc_en | store_done;
  assign pc_sel           = branch_exec ? (branch_taken ? PC_SEL_BRANCH : PC_SEL_PLUS4)
                                        : outs_q.pc_sel;
  assign instr_retired    = outs_q.instr_retired | store_done;
  assign trap             = outs_q.trap;
  assign state_o          = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks ALU, load, store, branch, illegal
// opcode, ack timeouts and asynchronous reset against hand-computed values.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        dmem_ack = 1'b0;
  logic        branch_taken = 1'b0;
  logic        imem_req, control_override, alu_src_imm, alu_src_pc;
  logic        dmem_req, dmem_we, reg_we, pc_en, instr_retired, trap;
  logic [31:0] instr_q;
  logic [1:0]  wb_sel, pc_sel;
  logic [2:0]  state_o;

  int checks = 0;
  int failures = 0;

  multicycle_ctrl #(.N(32), .OPCODE_W(7), .MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_ack(dmem_ack), .branch_taken(branch_taken), .imem_req(imem_req),
    .instr_q(instr_q), .control_override(control_override), .alu_src_imm(alu_src_imm),
    .alu_src_pc(alu_src_pc), .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_we(reg_we),
    .wb_sel(wb_sel), .pc_en(pc_en), .pc_sel(pc_sel), .instr_retired(instr_retired),
    .trap(trap), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset between edges, then one edge so the fetch request is raised.
  task automatic apply_reset();
    rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; branch_taken = 1'b0; imem_rdata = '0;
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic fetch_word(input logic [31:0] w);
    imem_ack = 1'b1; imem_rdata = w;
    tick();
    imem_ack = 1'b0; imem_rdata = 32'hDEADBEEF;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({state_o, instr_q, trap} !== {3'd0, 32'h0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL reset_state: got state=%0d ir=%h trap=%b expected 0/0/0", state_o, instr_q, trap);
    end
    checks++;
    if ({imem_req, control_override, alu_src_imm, alu_src_pc, dmem_req, dmem_we, reg_we,
         wb_sel, pc_en, pc_sel, instr_retired} !== 14'b0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got req=%b pc_en=%b reg_we=%b wb=%0d pcs=%0d expected all 0",
               imem_req, pc_en, reg_we, wb_sel, pc_sel);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if ({state_o, imem_req} !== {3'd0, 1'b1}) begin
      failures++;
      $display("[TB] FAIL reset_release: got state=%0d req=%b expected 0/1", state_o, imem_req);
    end
  endtask

  task automatic test_alu_op();
    fetch_word(32'h00500093);
    checks++;
    if ({state_o, instr_q, imem_req} !== {3'd1, 32'h00500093, 1'b0}) begin
      failures++;
      $display("[TB] FAIL addi_decode: got state=%0d ir=%h req=%b expected 1/00500093/0", state_o, instr_q, imem_req);
    end
    imem_ack = 1'b1; imem_rdata = 32'hFFFFFFFF;
    tick();
    imem_ack = 1'b0;
    checks++;
    if ({state_o, control_override, alu_src_imm, alu_src_pc, pc_en} !== {3'd2, 4'b0100}) begin
      failures++;
      $display("[TB] FAIL addi_exec: got state=%0d ovr=%b imm=%b pc=%b pc_en=%b expected 2/0/1/0/0",
               state_o, control_override, alu_src_imm, alu_src_pc, pc_en);
    end
    tick();
    checks++;
    if ({state_o, reg_we, wb_sel, pc_en, pc_sel, instr_retired, instr_q} !==
        {3'd4, 1'b1, 2'd0, 1'b1, 2'd0, 1'b1, 32'h00500093}) begin
      failures++;
      $display("[TB] FAIL addi_wb: got state=%0d we=%b wb=%0d pc_en=%b pcs=%0d ret=%b ir=%h expected 4/1/0/1/0/1/00500093",
               state_o, reg_we, wb_sel, pc_en, pc_sel, instr_retired, instr_q);
    end
    tick();
    checks++;
    if ({state_o, imem_req, reg_we, pc_en, instr_retired} !== {3'd0, 4'b1000}) begin
      failures++;
      $display("[TB] FAIL addi_done: got state=%0d req=%b we=%b pc_en=%b ret=%b expected 0/1/0/0/0",
               state_o, imem_req, reg_we, pc_en, instr_retired);
    end
  endtask

  task automatic test_load();
    fetch_word(32'h0040A103);
    tick();
    checks++;
    if ({state_o, control_override, alu_src_imm, alu_src_pc} !== {3'd2, 3'b110}) begin
      failures++;
      $display("[TB] FAIL lw_exec: got state=%0d ovr=%b imm=%b pc=%b expected 2/1/1/0",
               state_o, control_override, alu_src_imm, alu_src_pc);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({state_o, dmem_req, dmem_we, pc_en} !== {3'd3, 3'b100}) begin
        failures++;
        $display("[TB] FAIL lw_mem_wait%0d: got state=%0d req=%b we=%b pc_en=%b expected 3/1/0/0",
                 i, state_o, dmem_req, dmem_we, pc_en);
      end
      tick();
    end
    dmem_ack = 1'b1;
    #1;
    checks++;
    if ({state_o, dmem_req, pc_en, instr_retired} !== {3'd3, 3'b100}) begin
      failures++;
      $display("[TB] FAIL lw_mem_ack: got state=%0d req=%b pc_en=%b ret=%b expected 3/1/0/0",
               state_o, dmem_req, pc_en, instr_retired);
    end
    tick();
    dmem_ack = 1'b0;
    checks++;
    if ({state_o, reg_we, wb_sel, pc_en, pc_sel, dmem_req} !== {3'd4, 1'b1, 2'd1, 1'b1, 2'd0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL lw_wb: got state=%0d we=%b wb=%0d pc_en=%b pcs=%0d req=%b expected 4/1/1/1/0/0",
               state_o, reg_we, wb_sel, pc_en, pc_sel, dmem_req);
    end
    tick();
  endtask

  task automatic test_store();
    fetch_word(32'h0020A423);
    tick();
    checks++;
    if ({state_o, control_override, alu_src_imm, reg_we} !== {3'd2, 3'b110}) begin
      failures++;
      $display("[TB] FAIL sw_exec: got state=%0d ovr=%b imm=%b we=%b expected 2/1/1/0",
               state_o, control_override, alu_src_imm, reg_we);
    end
    tick();
    checks++;
    if ({state_o, dmem_req, dmem_we, reg_we, pc_en} !== {3'd3, 4'b1100}) begin
      failures++;
      $display("[TB] FAIL sw_mem: got state=%0d req=%b dwe=%b rwe=%b pc_en=%b expected 3/1/1/0/0",
               state_o, dmem_req, dmem_we, reg_we, pc_en);
    end
    dmem_ack = 1'b1;
    #1;
    checks++;
    if ({pc_en, instr_retired, pc_sel, reg_we} !== {1'b1, 1'b1, 2'd0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL sw_ack: got pc_en=%b ret=%b pcs=%0d we=%b expected 1/1/0/0",
               pc_en, instr_retired, pc_sel, reg_we);
    end
    tick();
    dmem_ack = 1'b0;
    checks++;
    if ({state_o, imem_req, reg_we, dmem_req} !== {3'd0, 3'b100}) begin
      failures++;
      $display("[TB] FAIL sw_done: got state=%0d req=%b we=%b dreq=%b expected 0/1/0/0",
               state_o, imem_req, reg_we, dmem_req);
    end
  endtask

  task automatic test_branch(input logic taken);
    branch_taken = taken;
    fetch_word(32'h00000463);
    tick();
    checks++;
    if ({state_o, pc_en, instr_retired, pc_sel, alu_src_imm, reg_we} !==
        {3'd2, 1'b1, 1'b1, {1'b0, taken}, 1'b0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL beq_exec_t%0d: got state=%0d pc_en=%b ret=%b pcs=%0d imm=%b we=%b expected 2/1/1/%0d/0/0",
               taken, state_o, pc_en, instr_retired, pc_sel, alu_src_imm, reg_we, taken);
    end
    tick();
    branch_taken = 1'b0;
    checks++;
    if ({state_o, imem_req, pc_en} !== {3'd0, 2'b10}) begin
      failures++;
      $display("[TB] FAIL beq_done_t%0d: got state=%0d req=%b pc_en=%b expected 0/1/0", taken, state_o, imem_req, pc_en);
    end
  endtask

  task automatic test_illegal_trap();
    logic stayed;
    fetch_word(32'h00000000);
    tick();
    checks++;
    if ({state_o, trap, imem_req, pc_en, reg_we, dmem_req} !== {3'd7, 5'b10000}) begin
      failures++;
      $display("[TB] FAIL illegal_trap: got state=%0d trap=%b req=%b pc_en=%b we=%b dreq=%b expected 7/1/0/0/0/0",
               state_o, trap, imem_req, pc_en, reg_we, dmem_req);
    end
    stayed = 1'b1;
    for (int i = 0; i < 20; i++) begin
      imem_ack = i[0]; dmem_ack = ~i[0];
      tick();
      if ({state_o, trap, imem_req, pc_en, instr_retired} !== {3'd7, 4'b1000}) stayed = 1'b0;
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;
    checks++;
    if (stayed !== 1'b1) begin
      failures++;
      $display("[TB] FAIL trap_sticky: got state=%0d trap=%b expected held in 7 with trap=1", state_o, trap);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({state_o, trap, instr_q} !== {3'd0, 1'b0, 32'h0}) begin
      failures++;
      $display("[TB] FAIL trap_reset: got state=%0d trap=%b ir=%h expected 0/0/0", state_o, trap, instr_q);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fetch_timeout();
    apply_reset();
    repeat (15) tick();
    checks++;
    if ({state_o, imem_req, trap} !== {3'd0, 2'b10}) begin
      failures++;
      $display("[TB] FAIL fetch_wait15: got state=%0d req=%b trap=%b expected 0/1/0", state_o, imem_req, trap);
    end
    tick();
    checks++;
    if ({state_o, trap, imem_req} !== {3'd7, 2'b10}) begin
      failures++;
      $display("[TB] FAIL fetch_timeout: got state=%0d trap=%b req=%b expected 7/1/0", state_o, trap, imem_req);
    end
  endtask

  task automatic test_ack_at_limit();
    apply_reset();
    repeat (15) tick();
    fetch_word(32'h00500093);
    checks++;
    if ({state_o, trap, instr_q} !== {3'd1, 1'b0, 32'h00500093}) begin
      failures++;
      $display("[TB] FAIL ack_at_limit: got state=%0d trap=%b ir=%h expected 1/0/00500093", state_o, trap, instr_q);
    end
    repeat (3) tick();
    checks++;
    if ({state_o, trap, imem_req} !== {3'd0, 2'b01}) begin
      failures++;
      $display("[TB] FAIL ack_at_limit_done: got state=%0d trap=%b req=%b expected 0/0/1", state_o, trap, imem_req);
    end
  endtask

  task automatic test_mem_timeout();
    fetch_word(32'h0040A103);
    tick();
    tick();
    repeat (15) tick();
    checks++;
    if ({state_o, dmem_req} !== {3'd3, 1'b1}) begin
      failures++;
      $display("[TB] FAIL mem_wait15: got state=%0d req=%b expected 3/1", state_o, dmem_req);
    end
    tick();
    checks++;
    if ({state_o, trap, dmem_req} !== {3'd7, 2'b10}) begin
      failures++;
      $display("[TB] FAIL mem_timeout: got state=%0d trap=%b req=%b expected 7/1/0", state_o, trap, dmem_req);
    end
  endtask

  task automatic test_reset_mid_mem();
    apply_reset();
    fetch_word(32'h0040A103);
    tick();
    tick();
    tick();
    checks++;
    if ({state_o, dmem_req} !== {3'd3, 1'b1}) begin
      failures++;
      $display("[TB] FAIL midmem_pre: got state=%0d req=%b expected 3/1", state_o, dmem_req);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({state_o, dmem_req, instr_q, imem_req, trap} !== {3'd0, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL midmem_async_reset: got state=%0d dreq=%b ir=%h req=%b trap=%b expected 0/0/0/0/0",
               state_o, dmem_req, instr_q, imem_req, trap);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if ({state_o, imem_req} !== {3'd0, 1'b1}) begin
      failures++;
      $display("[TB] FAIL midmem_restart: got state=%0d req=%b expected 0/1", state_o, imem_req);
    end
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_load();
    test_store();
    test_branch(1'b1);
    test_branch(1'b0);
    test_illegal_trap();
    test_fetch_timeout();
    test_ack_at_limit();
    test_mem_timeout();
    test_reset_mid_mem();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
